// File: rtl/fpgaminer_csr_slave.sv
// fpgaminer_csr_slave: Avalon-MM CSR block with shadowed work registers and golden-nonce FIFO
module fpgaminer_csr_slave #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [4:0]   avs_address,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    input  logic [3:0]   avs_byteenable,
    input  logic         avs_read,
    output logic [31:0]  avs_readdata,
    output logic         avs_readdatavalid,
    output logic         avs_waitrequest,
    output logic [255:0] work_data,
    output logic [255:0] work_midstate,
    output logic         work_valid,
    input  logic [31:0]  golden_nonce,
    input  logic         golden_nonce_valid,
    output logic         irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    logic [15:0][31:0]           shadow_q, shadow_d;
    logic [511:0]                work_q, work_d;
    logic                        work_valid_q, work_valid_d;
    logic                        irq_en_q, irq_en_d;
    logic                        overflow_q, overflow_d;
    logic [FIFO_DEPTH-1:0][31:0] fifo_q, fifo_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0]                  count_q, count_d;
    logic [31:0]                 readdata_q, readdata_d;
    logic                        readdatavalid_q, readdatavalid_d;

    logic        rd, ctrl_wr, status_wr, go, flush, pop, push, full, nonempty;
    logic [31:0] mask, rdata;

    // A simultaneous read and write is treated as a write only
    always_comb begin
        rd        = avs_read & ~avs_write;
        mask      = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                     {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
        ctrl_wr   = avs_write & (avs_address == 5'd16) & avs_byteenable[0];
        status_wr = avs_write & (avs_address == 5'd17) & avs_byteenable[0];
        go        = ctrl_wr & avs_writedata[0];
        flush     = ctrl_wr & avs_writedata[2];
        nonempty  = count_q != 5'd0;
        full      = count_q == DEPTH_C;
        pop       = rd & (avs_address == 5'd18) & nonempty;
        push      = golden_nonce_valid & ~flush & (~full | pop);
    end

    // Read mux; an empty NONCE read and unmapped addresses return 0
    always_comb begin
        rdata = 32'd0;
        if (!avs_address[4])
            rdata = shadow_q[avs_address[3:0]];
        else if (avs_address == 5'd16)
            rdata = {30'd0, irq_en_q, 1'b0};
        else if (avs_address == 5'd17)
            rdata = {23'd0, count_q, 2'd0, overflow_q, nonempty};
        else if (avs_address == 5'd18)
            rdata = nonempty ? fifo_q[rd_ptr_q] : 32'd0;
    end

    // Next-state for shadows, committed work, control/status and the nonce FIFO
    always_comb begin
        shadow_d = shadow_q;
        if (avs_write && !avs_address[4])
            shadow_d[avs_address[3:0]] = (shadow_q[avs_address[3:0]] & ~mask) | (avs_writedata & mask);
        work_d          = go ? shadow_q : work_q;
        work_valid_d    = go;
        irq_en_d        = ctrl_wr ? avs_writedata[1] : irq_en_q;
        overflow_d      = (overflow_q & ~(status_wr & avs_writedata[1]))
                        | (golden_nonce_valid & ~flush & full & ~pop);
        fifo_d          = fifo_q;
        if (push)
            fifo_d[wr_ptr_q] = golden_nonce;
        rd_ptr_d        = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d        = flush ? '0 : wr_ptr_q + AW'(push);
        count_d         = flush ? 5'd0 : count_q + 5'(push) - 5'(pop);
        readdata_d      = rd ? rdata : 32'd0;
        readdatavalid_d = rd;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q        <= '0;
            work_q          <= '0;
            work_valid_q    <= 1'b0;
            irq_en_q        <= 1'b0;
            overflow_q      <= 1'b0;
            fifo_q          <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= 5'd0;
            readdata_q      <= 32'd0;
            readdatavalid_q <= 1'b0;
        end else begin
            shadow_q        <= shadow_d;
            work_q          <= work_d;
            work_valid_q    <= work_valid_d;
            irq_en_q        <= irq_en_d;
            overflow_q      <= overflow_d;
            fifo_q          <= fifo_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign avs_waitrequest   = 1'b0;
    assign work_data         = work_q[255:0];
    assign work_midstate     = work_q[511:256];
    assign work_valid        = work_valid_q;
    assign irq               = irq_en_q & (count_q != 5'd0);
endmodule

// File: doc/fpgaminer_csr_slave.md
# fpgaminer_csr_slave

Avalon-MM slave register block at the host-facing edge of the fpgaminer IP core, behind the system's mm_bridge. It accepts the host's 32-bit writes of the 256-bit data2 and midstate work words into shadow registers and commits them atomically to the hashing core on a GO command. It also queues golden nonces reported by the core in a small FIFO that the host reads back over the same Avalon-MM port.

## Interface
- FIFO_DEPTH, 4, golden-nonce FIFO depth; power of two, 2..16
- clk  in  1  sole clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  5  word address (host byte address / 4)
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_byteenable  in  4  per-byte write enables
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data qualifier
- avs_waitrequest  out  1  constant 0; no back-pressure
- work_data  out  256  committed data2; word i at bits [32i+31:32i]
- work_midstate  out  256  committed midstate; same word packing
- work_valid  out  1  one-cycle pulse on commit
- golden_nonce  in  32  nonce from core
- golden_nonce_valid  in  1  one-cycle push strobe
- irq  out  1  level interrupt = irq_en & FIFO non-empty

## Operation
- Address map:
  - 0-7: data2 shadow words 0-7, R/W.
  - 8-15: midstate shadow words 0-7, R/W.
  - 16: CONTROL.
    - bit0 GO, write-1 self-clearing, reads 0.
    - bit1 irq_en, R/W.
    - bit2 FLUSH, write-1 self-clearing, reads 0.
  - 17: STATUS, read-only except as noted.
    - bit0 non-empty.
    - bit1 overflow, sticky; write 1 to bit1 clears it.
    - bits[8:4] FIFO count.
  - 18: NONCE. A read pops the FIFO head; a read when empty returns 0 and changes no state.
  - 19-31: unmapped. Reads return 0; writes are ignored.
- Byte enables apply to all writable registers. Byte lane k updates bits [8k+7:8k] only.
- GO copies all 16 shadow words into work_data/work_midstate and pulses work_valid. Work outputs hold until the next GO.
- Shadows can be rewritten freely while the core works; nothing propagates to the core without GO.
- FIFO push on golden_nonce_valid:
  - Not full: the nonce is enqueued.
  - Full, no pop in the same cycle: the nonce is dropped and overflow sets.
  - Full, pop in the same cycle: pop and push both happen; count is unchanged and overflow does not set.
- FLUSH empties the FIFO and leaves overflow unchanged. A push in the FLUSH cycle is discarded.
- Read and write asserted together is illegal for the master. If it occurs, the write is performed and the read is ignored; no readdatavalid is generated.
- Reset values:
  - All shadows, work_data and work_midstate are 0.
  - work_valid, irq, avs_readdatavalid and avs_readdata are 0.
  - irq_en is 0.
  - The FIFO is empty and overflow is 0.
  - Reset mid-burst discards all in-flight state; no readdatavalid follows a read accepted in the reset cycle.

## Timing
- Writes are accepted in the cycle strobed; the register updates at that clock edge.
- A read of a shadow or CONTROL register issued the cycle after a write to it returns the new value.
- Reads have a fixed latency of 1. A read in cycle N gives avs_readdatavalid=1 and avs_readdata in cycle N+1.
- Back-to-back reads each produce one valid cycle.
- A NONCE read pops at the edge ending cycle N. avs_readdata in cycle N+1 is the pre-pop head.
- A STATUS read in cycle N+1 reflects the pop.
- GO written in cycle N: work_data/work_midstate update and work_valid=1 in cycle N+1, for exactly one cycle.
- Two consecutive GO writes produce two pulses.
- golden_nonce_valid in cycle N:
  - STATUS count increments from cycle N+1.
  - irq rises in cycle N+1 if irq_en is set.
- irq falls the cycle after the pop that empties the FIFO, or the cycle after irq_en is cleared.

## Test plan
- Write 0x00000000..0x07070707 to addresses 0-7 and 0x08080808..0x0F0F0F0F to addresses 8-15, then GO. Required response:
  - Work outputs stay 0 until the GO write.
  - One cycle after GO: work_data word0=0x00000000, word7=0x07070707; work_midstate word0=0x08080808, word7=0x0F0F0F0F.
  - work_valid is high for exactly one cycle.
- Write 0xFFFFFFFF to address 3, then 0x12345678 with byteenable 4'b0101. Readback gives 0xFF34FF78, with readdatavalid exactly 1 cycle after the read.
- Push nonces 0xA, 0xB, 0xC with irq_en=1. Required response:
  - irq is high and STATUS=0x31.
  - Three NONCE reads return 0xA, 0xB, 0xC.
  - irq drops after the third read.
  - A fourth read returns 0 and STATUS=0x00.
- Push 5 nonces 1..5 with FIFO_DEPTH=4. Required response:
  - STATUS=0x43.
  - Reads return 1, 2, 3, 4.
  - Writing 0x2 to STATUS clears overflow, giving STATUS=0x00.
- With the FIFO full, assert golden_nonce_valid=0x99 in the same cycle as a NONCE read. Required response:
  - The read returns the old head.
  - Count stays 4 and overflow stays 0.
  - 0x99 is the last entry read out.
- Load the shadows and push 2 nonces, then assert reset_n low mid-read. Required response:
  - No readdatavalid follows the read.
  - All outputs are 0, and STATUS and shadow readback are 0.
